uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_if.sv | 21 ++
 rtl/uart_rx_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Receive FIFO read-side bundle for uart_rx_ctrl.
// master = controller (word source), slave = consumer.
interface uart_rx_ctrl_if #(
  parameter int DBIT = 8
);
  logic            m_valid;
  logic            m_ready;
  logic [DBIT-1:0] m_data;
  logic            m_e_parity;
  logic            m_e_frame;

  modport master (
    output m_valid, m_data, m_e_parity, m_e_frame,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_e_parity, m_e_frame,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud divider, safe config apply, receive FIFO.
// Optional error counters enabled by `define UART_RX_CTRL_ERR_CNT_EN.
module uart_rx_ctrl #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            cfg_wr,
  input  logic [15:0]     cfg_div,
  input  logic [3:0]      cfg_dbit,
  input  logic [1:0]      cfg_pbit,
  input  logic [7:0]      cfg_sb_tick,
  input  logic [7:0]      cfg_os_tick,
  output logic            s_tick,
  output logic [3:0]      dbit,
  output logic [1:0]      pbit,
  output logic [7:0]      sb_tick,
  output logic [7:0]      os_tick,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_dout,
  input  logic            rx_e_parity,
  input  logic            rx_e_frame,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic            cfg_pending,
`ifdef UART_RX_CTRL_ERR_CNT_EN
  input  logic            err_cnt_clr,
  output logic [7:0]      par_err_cnt,
  output logic [7:0]      frm_err_cnt,
`endif
  uart_rx_ctrl_if.master  m
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = DBIT + 2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    APPLY
  } state_t;

  typedef struct packed {
    logic [15:0] div;
    logic [3:0]  dbit;
    logic [1:0]  pbit;
    logic [7:0]  sb;
    logic [7:0]  os;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    div:  16'd163,
    dbit: 4'd8,
    pbit: 2'd0,
    sb:   8'd32,
    os:   8'd32
  };

  state_t state_q;
  cfg_t   act_q;
  cfg_t   shd_q;
  cfg_t   cfg_in;
  logic   pend_q;

  assign cfg_in = '{
    div:  cfg_div,
    dbit: cfg_dbit,
    pbit: cfg_pbit,
    sb:   cfg_sb_tick,
    os:   cfg_os_tick
  };

  // Active config only moves in APPLY, i.e. between frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      act_q   <= CFG_RST;
      shd_q   <= CFG_RST;
      pend_q  <= 1'b0;
    end else begin
      if (cfg_wr) shd_q <= cfg_in;
      unique case (state_q)
        IDLE: begin
          if (pend_q && rx)
            state_q <= APPLY;
          else if (!rx)
            state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (rx_done_tick) state_q <= IDLE;
        end
        APPLY: begin
          act_q   <= shd_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (cfg_wr)
        pend_q <= 1'b1;
      else if (state_q == APPLY)
        pend_q <= 1'b0;
    end
  end

  logic [15:0] lim;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        hit;
  logic        tick_q;

  // div of zero is treated as one.
  assign lim   = (act_q.div == 16'd0) ? 16'd0 : act_q.div - 16'd1;
  assign hit   = (cnt_q >= lim);
  assign cnt_d = hit ? 16'd0 : cnt_q + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else if (state_q == APPLY) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= hit;
    end
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   fcnt_q;
  logic          ovr_q;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (fcnt_q == (AW+1)'(DEPTH));
  assign pop  = m.m_valid & m.m_ready;
  assign push = rx_done_tick & (~full | pop);
  assign drop = rx_done_tick & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {rx_dout, rx_e_parity, rx_e_frame};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      if (drop)
        ovr_q <= 1'b1;
      else if (ovr_clr)
        ovr_q <= 1'b0;
    end
  end

  assign m.m_valid = (fcnt_q != '0);
  assign {m.m_data, m.m_e_parity, m.m_e_frame} = mem_q[rp_q];

`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic [7:0] par_q;
  logic [7:0] frm_q;

  // Counts every flagged word, dropped ones included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= 8'd0;
      frm_q <= 8'd0;
    end else if (err_cnt_clr) begin
      par_q <= 8'd0;
      frm_q <= 8'd0;
    end else begin
      if (rx_done_tick && rx_e_parity && par_q != 8'hFF)
        par_q <= par_q + 8'd1;
      if (rx_done_tick && rx_e_frame && frm_q != 8'hFF)
        frm_q <= frm_q + 8'd1;
    end
  end

  assign par_err_cnt = par_q;
  assign frm_err_cnt = frm_q;
`endif

  assign s_tick      = tick_q;
  assign dbit        = act_q.dbit;
  assign pbit        = act_q.pbit;
  assign sb_tick     = act_q.sb;
  assign os_tick     = act_q.os;
  assign cfg_pending = pend_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed config/FIFO steps
// plus random FIFO traffic against a queue model.
module tb_uart_rx_ctrl;

  localparam int DBIT  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_div = 16'd163;
  logic [3:0]  cfg_dbit = 4'd8;
  logic [1:0]  cfg_pbit = 2'd0;
  logic [7:0]  cfg_sb_tick = 8'd32;
  logic [7:0]  cfg_os_tick = 8'd32;
  logic        s_tick;
  logic [3:0]  dbit;
  logic [1:0]  pbit;
  logic [7:0]  sb_tick;
  logic [7:0]  os_tick;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_dout = 8'd0;
  logic        rx_e_parity = 1'b0;
  logic        rx_e_frame = 1'b0;
  logic        overrun;
  logic        ovr_clr = 1'b0;
  logic        cfg_pending;
`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [7:0]  par_err_cnt;
  logic [7:0]  frm_err_cnt;
`endif

  uart_rx_ctrl_if #(.DBIT(DBIT)) mif ();

  uart_rx_ctrl #(.DBIT(DBIT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .cfg_wr       (cfg_wr),
    .cfg_div      (cfg_div),
    .cfg_dbit     (cfg_dbit),
    .cfg_pbit     (cfg_pbit),
    .cfg_sb_tick  (cfg_sb_tick),
    .cfg_os_tick  (cfg_os_tick),
    .s_tick       (s_tick),
    .dbit         (dbit),
    .pbit         (pbit),
    .sb_tick      (sb_tick),
    .os_tick      (os_tick),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_e_parity  (rx_e_parity),
    .rx_e_frame   (rx_e_frame),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr),
    .cfg_pending  (cfg_pending),
`ifdef UART_RX_CTRL_ERR_CNT_EN
    .err_cnt_clr  (err_cnt_clr),
    .par_err_cnt  (par_err_cnt),
    .frm_err_cnt  (frm_err_cnt),
`endif
    .m            (mif.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [9:0] q[$];
  bit         ovr_m = 1'b0;
  int         par_m = 0;
  int         frm_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " s_tick"},  32'(s_tick), 32'd0);
    chk({tag, " m_valid"}, 32'(mif.m_valid), 32'd0);
    chk({tag, " dbit"},    32'(dbit), 32'd8);
    chk({tag, " pbit"},    32'(pbit), 32'd0);
    chk({tag, " sb_tick"}, 32'(sb_tick), 32'd32);
    chk({tag, " os_tick"}, 32'(os_tick), 32'd32);
    chk({tag, " pending"}, 32'(cfg_pending), 32'd0);
    chk({tag, " overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    cfg_wr = 1'b0;
    rx = 1'b1;
    rx_done_tick = 1'b0;
    ovr_clr = 1'b0;
    mif.m_ready = 1'b0;
    q.delete();
    ovr_m = 1'b0;
    par_m = 0;
    frm_m = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock: drive FIFO-side inputs, advance model, check outputs.
  task automatic cyc(input bit done, input logic [9:0] w,
                     input bit rdy, input bit clr);
    bit pop;
    bit full;
    rx_done_tick = done;
    {rx_dout, rx_e_parity, rx_e_frame} = w;
    mif.m_ready = rdy;
    ovr_clr = clr;
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    if (done && full && !pop) ovr_m = 1'b1;
    else if (clr) ovr_m = 1'b0;
    if (pop) void'(q.pop_front());
    if (done && (!full || pop)) q.push_back(w);
    if (done && w[1] && par_m < 255) par_m++;
    if (done && w[0] && frm_m < 255) frm_m++;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    ovr_clr = 1'b0;
    mif.m_ready = 1'b0;
    chk("m_valid", 32'(mif.m_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_data",     32'(mif.m_data),     32'(q[0][9:2]));
      chk("m_e_parity", 32'(mif.m_e_parity), 32'(q[0][1]));
      chk("m_e_frame",  32'(mif.m_e_frame),  32'(q[0][0]));
    end
    chk("overrun", 32'(overrun), 32'(ovr_m));
`ifdef UART_RX_CTRL_ERR_CNT_EN
    chk("par_err_cnt", 32'(par_err_cnt), 32'(par_m));
    chk("frm_err_cnt", 32'(frm_err_cnt), 32'(frm_m));
`endif
  endtask

  task automatic measure_period(input string tag, input int exp,
                                input int budget);
    int first;
    int gap;
    first = -1;
    gap = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (s_tick) begin
        if (first < 0) first = i;
        else begin
          gap = i - first;
          break;
        end
      end
    end
    chk(tag, 32'(gap), 32'(exp));
  endtask

  task automatic write_cfg(input logic [15:0] dv, input logic [3:0] db,
                           input logic [1:0] pb, input logic [7:0] sb,
                           input logic [7:0] os);
    cfg_div = dv;
    cfg_dbit = db;
    cfg_pbit = pb;
    cfg_sb_tick = sb;
    cfg_os_tick = os;
    cfg_wr = 1'b1;
  endtask

  logic [9:0] w[6];
  logic [9:0] e[4];

  initial begin
    mif.m_ready = 1'b0;
    @(posedge clk);
    #1;

    do_reset("reset");
    measure_period("period div=163", 163, 400);

    write_cfg(16'd3, 4'd8, 2'd0, 8'd32, 8'd32);
    cyc(0, '0, 0, 0);
    cfg_wr = 1'b0;
    chk("pending after wr", 32'(cfg_pending), 32'd1);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    chk("pending after apply", 32'(cfg_pending), 32'd0);
    measure_period("period div=3", 3, 20);

    write_cfg(16'd0, 4'd8, 2'd2, 8'd16, 8'd48);
    cyc(0, '0, 0, 0);
    cfg_wr = 1'b0;
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    chk("pbit applied", 32'(pbit), 32'd2);
    chk("sb applied", 32'(sb_tick), 32'd16);
    chk("os applied", 32'(os_tick), 32'd48);
    measure_period("period div=0", 1, 10);

    rx = 1'b0;
    cyc(0, '0, 0, 0);
    rx = 1'b1;
    write_cfg(16'd3, 4'd7, 2'd0, 8'd32, 8'd32);
    cyc(0, '0, 0, 0);
    cfg_wr = 1'b0;
    chk("pending in frame", 32'(cfg_pending), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, 0);
      chk("dbit held in frame", 32'(dbit), 32'd8);
    end
    cyc(1, 10'h2A4, 0, 0);
    chk("dbit at done", 32'(dbit), 32'd8);
    cyc(0, '0, 0, 0);
    chk("dbit in idle", 32'(dbit), 32'd8);
    chk("pending in idle", 32'(cfg_pending), 32'd1);
    write_cfg(16'd3, 4'd5, 2'd0, 8'd32, 8'd32);
    cyc(0, '0, 0, 0);
    cfg_wr = 1'b0;
    chk("dbit after apply", 32'(dbit), 32'd7);
    chk("pending wr in apply", 32'(cfg_pending), 32'd1);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    chk("dbit second apply", 32'(dbit), 32'd5);
    chk("pending second apply", 32'(cfg_pending), 32'd0);

    write_cfg(16'd9, 4'd6, 2'd1, 8'd8, 8'd8);
    cyc(0, '0, 0, 0);
    cfg_wr = 1'b0;
    chk("pending before reset", 32'(cfg_pending), 32'd1);
    chk("fifo busy before reset", 32'(mif.m_valid), 32'd1);
    do_reset("mid reset");

    for (int i = 0; i < 6; i++) w[i] = 10'($urandom);
    for (int i = 0; i < 4; i++) cyc(1, w[i], 0, 0);
    cyc(1, w[4], 0, 1);
    chk("overrun set wins", 32'(overrun), 32'd1);
    chk("head kept", 32'(mif.m_data), 32'(w[0][9:2]));
    cyc(0, '0, 0, 1);
    chk("overrun cleared", 32'(overrun), 32'd0);
    cyc(1, w[5], 1, 0);
    chk("no overrun on pop", 32'(overrun), 32'd0);
    e[0] = w[1];
    e[1] = w[2];
    e[2] = w[3];
    e[3] = w[5];
    for (int k = 0; k < 4; k++) begin
      chk("drain valid", 32'(mif.m_valid), 32'd1);
      chk("drain word", 32'({mif.m_data, mif.m_e_parity, mif.m_e_frame}),
          32'(e[k]));
      cyc(0, '0, 1, 0);
    end
    chk("drained empty", 32'(mif.m_valid), 32'd0);

    do_reset("reset rand");
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom), 10'($urandom), 1'($urandom),
          ($urandom_range(0, 7) == 0));

`ifdef UART_RX_CTRL_ERR_CNT_EN
    do_reset("reset err");
    for (int i = 0; i < 300; i++) cyc(1, {8'($urandom), 2'b10}, 1, 0);
    chk("par_err_cnt sat", 32'(par_err_cnt), 32'd255);
    chk("frm_err_cnt zero", 32'(frm_err_cnt), 32'd0);
    err_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    err_cnt_clr = 1'b0;
    par_m = 0;
    chk("par_err_cnt clr", 32'(par_err_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
